m2p_gray_counter_ifc: RTL and testbench
=======================================

Name: m2p_gray_counter_ifc

Overview:
Method-to-pipe marshaller for GrayCounterIfc; the sending end of the pipe that the P2M block decodes. It accepts method invocations (increment, decrement, writeGray, writeBin) on its server-side ports. Each accepted call becomes a 144-bit pipe message: a 16-bit method tag plus a 128-bit payload. Messages are buffered in a small FIFO and drained through an enq/RDY handshake toward the host transport.

Parameters:
WIDTH, 4, counter data width of writeGray/writeBin payloads (1..128)
DEPTH, 4, message FIFO entries (power of two, >=2)

Ports:
CLK  input  1  clock
RST  input  1  reset, synchronous, active-high
increment__ENA  input  1  invoke increment
increment__RDY  output  1  increment may be invoked
decrement__ENA  input  1  invoke decrement
decrement__RDY  output  1  decrement may be invoked
writeGray__ENA  input  1  invoke writeGray
writeGray$v  input  WIDTH  writeGray argument
writeGray__RDY  output  1  writeGray may be invoked
writeBin__ENA  input  1  invoke writeBin
writeBin$v  input  WIDTH  writeBin argument
writeBin__RDY  output  1  writeBin may be invoked
pipe$enq__ENA  output  1  message valid toward transport
pipe$enq$v  output  144  message: [143:128] tag, [127:0] payload
pipe$enq__RDY  input  1  transport accepts message
drop_count  output  8  saturating count of rejected invocations

Interface: one clock CLK; reset RST is synchronous and active-high.

Behaviour:
- Method tags: increment=16'd0, decrement=16'd1, writeGray=16'd3, writeBin=16'd5. Tags 2 and 4 are never generated.
- Payload:
  - writeGray/writeBin: argument zero-extended into [WIDTH-1:0]; all other bits 0.
  - increment/decrement: payload all 0.
- FIFO: DEPTH entries of 144 bits, wrapping read/write pointers, occupancy count 0..DEPTH.
- All four *__RDY signals = (count < DEPTH). They are derived from registered state only, so there is no combinational path from pipe$enq__RDY.
- Push: on a cycle where RDY is high and at least one ENA is high, exactly one message is written.
  - Fixed priority: increment > decrement > writeGray > writeBin.
  - When more than one ENA is high, only the winner is enqueued. drop_count increments by 1 that cycle, regardless of how many losers there are.
- ENA while RDY is low: the call is ignored and drop_count increments by 1.
- drop_count saturates at 255.
- Output side: pipe$enq__ENA = (count != 0) and pipe$enq$v = head entry, both driven from registers.
  - Pop when pipe$enq__ENA && pipe$enq__RDY.
  - pipe$enq$v is held stable while ENA is high and RDY is low.
- Simultaneous push and pop: count is unchanged and pointers both advance. This is legal at any occupancy 1..DEPTH-1.
  - At count==DEPTH, a pop frees space only from the next cycle; RDY stays low in the current cycle.
- Latency: a call accepted in cycle N is visible on pipe$enq__ENA in cycle N+1 if the FIFO was empty.
- Ordering: strict FIFO; messages leave in acceptance order.
- Reset values: count=0, pointers=0, pipe$enq__ENA=0, pipe$enq$v=0, *__RDY=1 (from the cycle after reset deasserts), drop_count=0.
- Reset asserted mid-operation: all queued messages are discarded without emission and all ENAs are ignored while RST is high.

Optional Feature:
M2P_SEQNUM_EN
- Defined:
  - An 8-bit sequence counter, reset to 0, is stamped into payload [127:120] of every enqueued message.
  - It increments by 1 per enqueued message and wraps 255->0.
  - Dropped calls do not consume a number.
  - WIDTH must be <=120 (static assertion).
- Undefined: payload [127:120] is 0 (except argument bits when WIDTH>120) and no counter is instantiated.

Test Plan:
- Reset, idle, pipe$enq__RDY=1 -> pipe$enq__ENA=0, all RDY=1, drop_count=0.
- writeGray with $v=4'hA, pipe$enq__RDY=1 -> next cycle pipe$enq$v = {16'd3, 124'd0, 4'hA} with ENA=1; popped, then ENA=0.
- pipe$enq__RDY=0; issue increment, decrement, writeBin(4'h7), increment (DEPTH=4) -> all RDY=0 after the 4th call; a 5th call leaves drop_count=1.
  - Then RDY=1 -> messages emitted in order with tags 0,1,5,0; writeBin payload [3:0]=4'h7.
- Same cycle increment__ENA=1 and writeBin__ENA=1 -> only tag 0 is enqueued and drop_count increments by exactly 1.
- FIFO with 2 entries and RST pulsed for 1 cycle -> pipe$enq__ENA=0 next cycle, count=0, drop_count=0, and no stale message appears afterwards.
- M2P_SEQNUM_EN defined; 257 increments with RDY=1 -> [127:120] runs 0..255 then 0 on the 257th message.

Source files
------------

// File: rtl/m2p_gray_counter_ifc.sv
// Method-to-pipe marshaller for GrayCounterIfc: method calls become 144-bit {tag, payload} messages in a FIFO.
// Optional macro M2P_SEQNUM_EN stamps an 8-bit sequence number into payload [127:120].
module m2p_gray_counter_ifc #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             increment__ENA,
  output logic             increment__RDY,
  input  logic             decrement__ENA,
  output logic             decrement__RDY,
  input  logic             writeGray__ENA,
  input  logic [WIDTH-1:0] writeGray_v,
  output logic             writeGray__RDY,
  input  logic             writeBin__ENA,
  input  logic [WIDTH-1:0] writeBin_v,
  output logic             writeBin__RDY,
  output logic             pipe_enq__ENA,
  output logic [143:0]     pipe_enq_v,
  input  logic             pipe_enq__RDY,
  output logic [7:0]       drop_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW + 1)'(DEPTH);

  logic [PW:0]   count_q, count_d;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [143:0]  mem_q [DEPTH];
  logic [7:0]    drop_q;

  logic          rdy;
  logic          any_ena;
  logic          multi_ena;
  logic [2:0]    n_ena;
  logic          push;
  logic          pop;
  logic          drop_inc;
  logic [15:0]   tag;
  logic [127:0]  payload;

`ifdef M2P_SEQNUM_EN
  logic [7:0] seq_q;

  if (WIDTH > 120) begin : g_width_chk
    $error("WIDTH must be <= 120 when the sequence number occupies payload [127:120]");
  end
`endif

  // Readiness depends only on registered occupancy; a same-cycle pop never opens space.
  assign rdy = (count_q < DEPTH_C);

  always_comb begin
    n_ena     = {2'b00, increment__ENA} + {2'b00, decrement__ENA}
              + {2'b00, writeGray__ENA} + {2'b00, writeBin__ENA};
    any_ena   = (n_ena != 3'd0);
    multi_ena = (n_ena > 3'd1);
    push      = any_ena && rdy;
    pop       = (count_q != '0) && pipe_enq__RDY;
    drop_inc  = any_ena && (!rdy || multi_ena);
    tag       = 16'd0;
    payload   = '0;
    if (increment__ENA) begin
      tag = 16'd0;
    end else if (decrement__ENA) begin
      tag = 16'd1;
    end else if (writeGray__ENA) begin
      tag = 16'd3;
      payload[WIDTH-1:0] = writeGray_v;
    end else if (writeBin__ENA) begin
      tag = 16'd5;
      payload[WIDTH-1:0] = writeBin_v;
    end
`ifdef M2P_SEQNUM_EN
    payload[127:120] = seq_q;
`endif
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      drop_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {tag, payload};
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
      if (drop_inc && (drop_q != 8'hFF)) begin
        drop_q <= drop_q + 8'd1;
      end
    end
  end

`ifdef M2P_SEQNUM_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      seq_q <= '0;
    end else if (push) begin
      seq_q <= seq_q + 8'd1;
    end
  end
`endif

  assign increment__RDY = rdy;
  assign decrement__RDY = rdy;
  assign writeGray__RDY = rdy;
  assign writeBin__RDY  = rdy;
  assign pipe_enq__ENA  = (count_q != '0);
  assign pipe_enq_v     = mem_q[rd_ptr_q];
  assign drop_count     = drop_q;

endmodule

// File: tb/tb_m2p_gray_counter_ifc.sv
// Bench for m2p_gray_counter_ifc: directed steps plus random traffic against a queue-based message model.
// Follows M2P_SEQNUM_EN when it is defined for the build.
module tb_m2p_gray_counter_ifc;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;

  // clock/reset block
  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  logic             inc, dec, wg, wb, prdy;
  logic [WIDTH-1:0] wgv, wbv;
  logic             inc_rdy, dec_rdy, wg_rdy, wb_rdy;
  logic             enq_ena;
  logic [143:0]     enq_v;
  logic [7:0]       drop;

  m2p_gray_counter_ifc #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .increment__ENA (inc),
    .increment__RDY (inc_rdy),
    .decrement__ENA (dec),
    .decrement__RDY (dec_rdy),
    .writeGray__ENA (wg),
    .writeGray_v    (wgv),
    .writeGray__RDY (wg_rdy),
    .writeBin__ENA  (wb),
    .writeBin_v     (wbv),
    .writeBin__RDY  (wb_rdy),
    .pipe_enq__ENA  (enq_ena),
    .pipe_enq_v     (enq_v),
    .pipe_enq__RDY  (prdy),
    .drop_count     (drop)
  );

  // scoreboard / reference model
  logic [143:0] exp_q[$];
  int           exp_drop;
  int           exp_seq;
  bit           fresh;
  int           errors = 0;
  int           checks = 0;

  task automatic check(input string tag, input logic [143:0] obs, input logic [143:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [143:0] mk_msg(input int mtag, input logic [WIDTH-1:0] arg);
    logic [143:0] m;
    m = (144'(mtag) << 128) | 144'(arg);
`ifdef M2P_SEQNUM_EN
    m = m | (144'(exp_seq % 256) << 120);
`endif
    return m;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    exp_drop = 0;
    exp_seq  = 0;
    fresh    = 1'b1;
  endtask

  task automatic check_outputs();
    logic r;
    r = (exp_q.size() < DEPTH);
    check("inc_rdy", 144'(inc_rdy), 144'(r));
    check("dec_rdy", 144'(dec_rdy), 144'(r));
    check("wg_rdy", 144'(wg_rdy), 144'(r));
    check("wb_rdy", 144'(wb_rdy), 144'(r));
    check("enq_ena", 144'(enq_ena), 144'(exp_q.size() != 0));
    if (exp_q.size() != 0) check("enq_v", enq_v, exp_q[0]);
    else if (fresh) check("enq_v_rst", enq_v, 144'd0);
    check("drop_count", 144'(drop), 144'(exp_drop));
  endtask

  // driver task: called at a negedge; checks, drives one cycle, advances the model
  task automatic step(input logic r, input logic i, input logic d, input logic g,
                      input logic [WIDTH-1:0] gv, input logic b, input logic [WIDTH-1:0] bv,
                      input logic pr);
    bit room;
    int n;
    check_outputs();
    RST = r; inc = i; dec = d; wg = g; wgv = gv; wb = b; wbv = bv; prdy = pr;
    if (r) begin
      model_reset();
    end else begin
      room = (exp_q.size() < DEPTH);
      n = int'(i) + int'(d) + int'(g) + int'(b);
      if (exp_q.size() != 0 && pr) void'(exp_q.pop_front());
      if (n != 0 && room) begin
        if (i)      exp_q.push_back(mk_msg(0, '0));
        else if (d) exp_q.push_back(mk_msg(1, '0));
        else if (g) exp_q.push_back(mk_msg(3, gv));
        else        exp_q.push_back(mk_msg(5, bv));
        exp_seq++;
        fresh = 1'b0;
      end
      if (n != 0 && (!room || n > 1) && exp_drop < 255) exp_drop++;
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic idle(input logic pr);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, pr);
  endtask

  initial begin
    RST = 1'b1; inc = 1'b0; dec = 1'b0; wg = 1'b0; wb = 1'b0;
    wgv = '0; wbv = '0; prdy = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    model_reset();

    // reset state and idle
    idle(1'b1);
    idle(1'b1);

    // single writeGray, popped immediately
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'hA, 1'b0, '0, 1'b1);
    check("wg_msg", enq_v, {16'd3, 124'd0, 4'hA} | (exp_q.size() != 0 ? exp_q[0] & {8'd0, 8'd0, 128'd0} : 144'd0));
    idle(1'b1);
    idle(1'b1);

    // fill with transport stalled, then one dropped call
    step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 4'h7, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    check("drop_after_full", 144'(drop), 144'd1);
    idle(1'b0);
    repeat (6) idle(1'b1);

    // simultaneous calls: only the winner is queued
    step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b1, 4'h3, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // reset with two entries queued
    step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    repeat (4) idle(1'b1);

    // long run of increments exercises sequence wrap when enabled
    repeat (260) step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    repeat (3) idle(1'b1);

    // random traffic
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0), WIDTH'($urandom_range(0, 15)),
           ($urandom_range(0, 3) == 0), WIDTH'($urandom_range(0, 15)),
           ($urandom_range(0, 1) == 1));
    end
    repeat (6) idle(1'b1);

    // drop counter saturation
    repeat (300) step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    check("drop_saturated", 144'(drop), 144'd255);
    repeat (6) idle(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
